clk_div_prog: RTL and testbench

- Parametrised successor to the board clock divider.
- Keeps the free-running clkdiv bus.
- Replaces the fixed-tap Clk_CPU with a registered, glitch-free CPU clock with:
  - a programmable half-period;
  - four modes (fast, slow, runtime-configured, single-step);
  - a pause that only takes effect at a low-phase boundary.
- Sits at top level between the board oscillator/switches and the CPU and peripheral clock inputs.

---
 rtl/clk_div_prog_if.sv | 16 +
 rtl/clk_div_prog.sv | 94 +++++++++
 tb/tb_clk_div_prog.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: mode/pause/step controls in, clkdiv/Clk_CPU/cpu_tick/paused out
interface clk_div_prog_if #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 24
);
  logic [1:0]       mode;
  logic [DIV_W-1:0] div_cfg;
  logic             SW_Pause;
  logic             step;
  logic [CNT_W-1:0] clkdiv;
  logic             Clk_CPU;
  logic             cpu_tick;
  logic             paused;
  modport master (output mode, div_cfg, SW_Pause, step, input clkdiv, Clk_CPU, cpu_tick, paused);
  modport slave (input mode, div_cfg, SW_Pause, step, output clkdiv, Clk_CPU, cpu_tick, paused);
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: free-running clkdiv plus glitch-free programmable Clk_CPU; ports clk, rst, bus(mode, div_cfg, SW_Pause, step -> clkdiv, Clk_CPU, cpu_tick, paused)
module clk_div_prog #(
  parameter int CNT_W       = 32,
  parameter int DIV_W       = 24,
  parameter int FAST_HALF   = 8,
  parameter int SLOW_HALF   = 2097152,
  parameter int STEP_HI_CYC = 4
) (
  input logic          clk,
  input logic          rst,
  clk_div_prog_if.slave bus
);
  typedef enum logic [2:0] {RUN_LO, RUN_HI, PAUSED, STEP_IDLE, STEP_HI} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] clkdiv;
  logic [DIV_W-1:0] hc, hc_n, h_act, h_act_n, h_sel;
  logic [2:0]       sync;
  logic             clk_cpu, clk_cpu_n, tick, tick_n;
  logic             last, step_last, step_rise;
  assign step_rise = sync[1] & ~sync[2];
  assign last      = hc == h_act - 1'b1;
  assign step_last = hc == DIV_W'(STEP_HI_CYC - 1);
  assign h_sel     = bus.mode == 2'd0 ? DIV_W'(FAST_HALF) :
                     bus.mode == 2'd1 ? DIV_W'(SLOW_HALF) :
                     bus.div_cfg == '0 ? DIV_W'(1) : bus.div_cfg;
  always_comb begin
    state_n = state;
    hc_n    = hc + 1'b1;
    h_act_n = h_act;
    tick_n  = 1'b0;
    case (state)
      RUN_LO:
        if (last) begin
          hc_n = '0;
          if (bus.SW_Pause) state_n = PAUSED;
          else if (bus.mode == 2'd3) state_n = STEP_IDLE;
          else begin
            h_act_n = h_sel;
            state_n = RUN_HI;
            tick_n  = 1'b1;
          end
        end
      RUN_HI:
        if (last) begin
          hc_n    = '0;
          state_n = RUN_LO;
        end
      PAUSED: begin
        hc_n = '0;
        if (!bus.SW_Pause) state_n = RUN_LO;
      end
      STEP_IDLE: begin
        hc_n = '0;
        if (bus.SW_Pause || bus.mode != 2'd3) state_n = RUN_LO;
        else if (step_rise) begin
          state_n = STEP_HI;
          tick_n  = 1'b1;
        end
      end
      STEP_HI:
        if (step_last) begin
          hc_n    = '0;
          state_n = STEP_IDLE;
        end
      default: begin
        hc_n    = '0;
        state_n = RUN_LO;
      end
    endcase
    clk_cpu_n = state_n == RUN_HI || state_n == STEP_HI;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clkdiv  <= '0;
      state   <= RUN_LO;
      hc      <= '0;
      h_act   <= DIV_W'(FAST_HALF);
      sync    <= '0;
      clk_cpu <= 1'b0;
      tick    <= 1'b0;
    end else begin
      clkdiv  <= clkdiv + 1'b1;
      state   <= state_n;
      hc      <= hc_n;
      h_act   <= h_act_n;
      sync    <= {sync[1:0], bus.step};
      clk_cpu <= clk_cpu_n;
      tick    <= tick_n;
    end
  assign bus.clkdiv   = clkdiv;
  assign bus.Clk_CPU  = clk_cpu;
  assign bus.cpu_tick = tick;
  assign bus.paused   = state == PAUSED;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: phase-level model compared every cycle plus directed literal timing checks
module tb_clk_div_prog;
  localparam int SLOW = 40;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  clk_div_prog_if #(.CNT_W(32), .DIV_W(24)) bus ();
  clk_div_prog #(.SLOW_HALF(SLOW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask
  typedef enum {M_LO, M_HI, M_PAU, M_IDL, M_SHI} ph_t;
  ph_t         ph = M_LO;
  int          rem = 8;
  int          h = 8;
  logic [31:0] m_div = 0;
  logic        m_tick = 0;
  logic [2:0]  sh = 0;
  bit          rise;
  function automatic int sel();
    return bus.mode == 0 ? 8 : bus.mode == 1 ? SLOW : (bus.div_cfg == 0 ? 1 : int'(bus.div_cfg));
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      ph = M_LO; rem = 8; h = 8; m_div = 0; m_tick = 0; sh = 0;
    end else begin
      rise = sh[1] && !sh[2];
      sh = {sh[1:0], bus.step};
      m_div++;
      m_tick = 0;
      case (ph)
        M_LO:
          if (rem > 1) rem--;
          else if (bus.SW_Pause) ph = M_PAU;
          else if (bus.mode == 3) ph = M_IDL;
          else begin h = sel(); rem = h; ph = M_HI; m_tick = 1; end
        M_HI: if (rem > 1) rem--; else begin ph = M_LO; rem = h; end
        M_PAU: if (!bus.SW_Pause) begin ph = M_LO; rem = h; end
        M_IDL:
          if (bus.SW_Pause || bus.mode != 3) begin ph = M_LO; rem = h; end
          else if (rise) begin ph = M_SHI; rem = 4; m_tick = 1; end
        M_SHI: if (rem > 1) rem--; else ph = M_IDL;
      endcase
    end
  always @(negedge clk)
    if (!rst) begin
      chk("m_clkdiv", bus.clkdiv, m_div);
      chk("m_Clk_CPU", bus.Clk_CPU, ph == M_HI || ph == M_SHI);
      chk("m_cpu_tick", bus.cpu_tick, m_tick);
      chk("m_paused", bus.paused, ph == M_PAU);
    end
  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_rise();
    int k = 0;
    do begin adv(1); k++; end while (!bus.cpu_tick && k < 200);
    chk("rise_seen", bus.cpu_tick, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    bus.mode = 0; bus.div_cfg = 0; bus.SW_Pause = 0; bus.step = 0;
    adv(2);
    chk("rst_clkdiv", bus.clkdiv, 0);
    chk("rst_clk", bus.Clk_CPU, 0);
    chk("rst_tick", bus.cpu_tick, 0);
    chk("rst_paused", bus.paused, 0);
    rst = 0;
    adv(7); chk("f_lo7_clk", bus.Clk_CPU, 0); chk("f_lo7_div", bus.clkdiv, 7);
    adv(1); chk("f_rise_clk", bus.Clk_CPU, 1); chk("f_rise_tick", bus.cpu_tick, 1); chk("f_rise_div", bus.clkdiv, 8);
    adv(1); chk("f_tick_once", bus.cpu_tick, 0);
    adv(6); chk("f_hi_end", bus.Clk_CPU, 1);
    adv(1); chk("f_fall", bus.Clk_CPU, 0);
    adv(8); chk("f_rise2", bus.cpu_tick, 1);
    bus.mode = 2; bus.div_cfg = 3;
    wait_rise();
    adv(1); bus.div_cfg = 5;
    adv(1); chk("d3_hi", bus.Clk_CPU, 1);
    adv(1); chk("d3_fall", bus.Clk_CPU, 0);
    adv(3); chk("d3_rise", bus.cpu_tick, 1);
    adv(4); chk("d5_hi", bus.Clk_CPU, 1);
    adv(1); chk("d5_fall", bus.Clk_CPU, 0);
    adv(5); chk("d5_rise", bus.cpu_tick, 1);
    bus.div_cfg = 0;
    wait_rise();
    adv(1); chk("d0_fall", bus.Clk_CPU, 0);
    adv(1); chk("d0_rise", bus.cpu_tick, 1);
    adv(2); chk("d0_rise2", bus.cpu_tick, 1);
    bus.mode = 0;
    wait_rise();
    adv(2); bus.SW_Pause = 1;
    adv(5); chk("p_hi_full", bus.Clk_CPU, 1);
    adv(1); chk("p_fall", bus.Clk_CPU, 0); chk("p_not_yet", bus.paused, 0);
    adv(7); chk("p_lo_full", bus.paused, 0);
    adv(1); chk("p_enter", bus.paused, 1);
    adv(10); chk("p_hold", bus.paused, 1); chk("p_hold_clk", bus.Clk_CPU, 0);
    bus.SW_Pause = 0;
    adv(1); chk("p_leave", bus.paused, 0);
    adv(7); chk("p_relo", bus.Clk_CPU, 0);
    adv(1); chk("p_rise", bus.cpu_tick, 1);
    bus.mode = 3;
    adv(20); chk("s_idle", bus.Clk_CPU, 0);
    bus.step = 1;
    adv(2); chk("s1_wait", bus.Clk_CPU, 0);
    adv(1); chk("s1_rise", bus.Clk_CPU, 1); chk("s1_tick", bus.cpu_tick, 1);
    bus.step = 0;
    adv(3); chk("s1_hi", bus.Clk_CPU, 1);
    adv(1); chk("s1_fall", bus.Clk_CPU, 0);
    adv(50);
    bus.step = 1;
    adv(2); chk("s2_wait", bus.Clk_CPU, 0);
    adv(1); chk("s2_rise", bus.Clk_CPU, 1); chk("s2_tick", bus.cpu_tick, 1);
    bus.step = 0;
    adv(1); bus.step = 1;
    adv(1); bus.step = 0;
    adv(1); chk("s2_hi", bus.Clk_CPU, 1);
    adv(1); chk("s2_fall", bus.Clk_CPU, 0);
    adv(10); chk("s2_no_extra", bus.Clk_CPU, 0);
    bus.mode = 1;
    wait_rise();
    adv(80); chk("sl_period", bus.cpu_tick, 1);
    adv(39); chk("sl_hi", bus.Clk_CPU, 1);
    adv(1); chk("sl_fall", bus.Clk_CPU, 0);
    adv(10); bus.mode = 0;
    adv(29); chk("sl_lo_kept", bus.Clk_CPU, 0);
    adv(1); chk("sl_rise", bus.cpu_tick, 1);
    adv(7); chk("sl_fast_hi", bus.Clk_CPU, 1);
    adv(1); chk("sl_fast_fall", bus.Clk_CPU, 0);
    wait_rise();
    adv(3);
    #2 rst = 1;
    #1;
    chk("ar_clk", bus.Clk_CPU, 0);
    chk("ar_div", bus.clkdiv, 0);
    chk("ar_tick", bus.cpu_tick, 0);
    @(negedge clk);
    rst = 0;
    adv(7); chk("ar_lo7", bus.Clk_CPU, 0); chk("ar_div7", bus.clkdiv, 7);
    adv(1); chk("ar_rise", bus.Clk_CPU, 1); chk("ar_rise_tick", bus.cpu_tick, 1);
    adv(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
